// File: rtl/fp_operand_unpacker_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fp_operand_unpacker_seq
//  Description : Registered, handshaked IEEE754 operand decoder. Accepts two
//                packed operands (single or double, chosen by one operation
//                bit), classifies each one and normalises subnormals one bit
//                per cycle so the significand leaves with its leading one at
//                the hidden-bit position.
//  Ports       : clk, rst                 clock / synchronous active-high reset
//                in_valid, in_ready       input handshake (ready in IDLE only)
//                inp_a, inp_b, operation  packed operands, operation code
//                out_valid, out_ready     output handshake
//                op                       captured operation
//                out_a, out_b             significands, hidden bit included
//                exp_a, exp_b             signed exponents (biased scale)
//                sign_*, inf_*, zero_*, nan_*, normal_*, subnormal_*  flags
//  Revision    : 1.0  initial release
// ============================================================================
module fp_operand_unpacker_seq #(
    parameter int REG_W     = 64,
    parameter int OP_BITS   = 2,
    parameter int FMT_BIT   = 1,
    parameter int S_EXP_W   = 8,
    parameter int S_MAN_W   = 23,
    parameter int D_EXP_W   = 11,
    parameter int D_MAN_W   = 52,
    parameter int SIG_W     = D_MAN_W + 1,
    parameter int EXP_OUT_W = D_EXP_W + 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [REG_W-1:0]            inp_a,
    input  logic [REG_W-1:0]            inp_b,
    input  logic [OP_BITS-1:0]          operation,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OP_BITS-1:0]          op,
    output logic [SIG_W-1:0]            out_a,
    output logic [SIG_W-1:0]            out_b,
    output logic signed [EXP_OUT_W-1:0] exp_a,
    output logic signed [EXP_OUT_W-1:0] exp_b,
    output logic                        sign_a,
    output logic                        sign_b,
    output logic                        inf_a,
    output logic                        inf_b,
    output logic                        zero_a,
    output logic                        zero_b,
    output logic                        nan_a,
    output logic                        nan_b,
    output logic                        normal_a,
    output logic                        normal_b,
    output logic                        subnormal_a,
    output logic                        subnormal_b
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_NORM = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic signed [EXP_OUT_W-1:0] c_ONE = 1;

    typedef struct packed {
        logic                 sign;
        logic                 inf;
        logic                 zero;
        logic                 nan;
        logic                 normal;
        logic                 sub;
        logic [EXP_OUT_W-1:0] exp;
        logic [SIG_W-1:0]     sig;
    } t_dec;

    // Field extraction and classification of one operand. Single format
    // looks only at the low 32 bits; its fields are zero-extended.
    function automatic t_dec f_decode(input logic [REG_W-1:0] v, input logic isDbl);
        t_dec               d;
        logic [D_EXP_W-1:0] e;
        logic [D_MAN_W-1:0] m;
        logic               eMax;
        d = '0;
        if (isDbl) begin
            e      = v[D_EXP_W+D_MAN_W-1 -: D_EXP_W];
            m      = v[D_MAN_W-1:0];
            eMax   = &e;
            d.sign = v[D_EXP_W+D_MAN_W];
        end else begin
            e      = {{(D_EXP_W-S_EXP_W){1'b0}}, v[S_EXP_W+S_MAN_W-1 -: S_EXP_W]};
            m      = {{(D_MAN_W-S_MAN_W){1'b0}}, v[S_MAN_W-1:0]};
            eMax   = &e[S_EXP_W-1:0];
            d.sign = v[S_EXP_W+S_MAN_W];
        end
        d.zero   = (e == '0) && (m == '0);
        d.sub    = (e == '0) && (m != '0);
        d.inf    = eMax && (m == '0);
        d.nan    = eMax && (m != '0);
        d.normal = (e != '0) && !eMax;
        d.sig    = {{(SIG_W-D_MAN_W){1'b0}}, m};
        d.exp    = {{(EXP_OUT_W-D_EXP_W){1'b0}}, e};
        if (d.normal) begin
            if (isDbl) d.sig[D_MAN_W] = 1'b1;
            else       d.sig[S_MAN_W] = 1'b1;
        end
        if (d.zero) d.exp = '0;
        // Subnormals start at exponent 1 and walk down while normalising.
        if (d.sub)  d.exp = c_ONE;
        return d;
    endfunction

    logic [1:0]                  r_state;
    logic                        r_inReady;
    logic                        r_outValid;
    logic [OP_BITS-1:0]          r_op;
    logic [SIG_W-1:0]            r_sigA, r_sigB;
    logic signed [EXP_OUT_W-1:0] r_expA, r_expB;
    logic                        r_signA, r_signB, r_infA, r_infB, r_zeroA, r_zeroB;
    logic                        r_nanA, r_nanB, r_normA, r_normB, r_subA, r_subB;

    t_dec             w_decA, w_decB;
    logic             w_isDbl;
    logic             w_shA, w_shB;
    logic [SIG_W-1:0] w_nSigA, w_nSigB;
    logic             w_nAlignA, w_nAlignB;
    logic             w_normDone;

    always_comb begin
        w_decA  = f_decode(inp_a, operation[FMT_BIT]);
        w_decB  = f_decode(inp_b, operation[FMT_BIT]);
        w_isDbl = r_op[FMT_BIT];
        // Only a subnormal operand not yet aligned shifts; the other holds.
        w_shA   = r_subA && !(w_isDbl ? r_sigA[D_MAN_W] : r_sigA[S_MAN_W]);
        w_shB   = r_subB && !(w_isDbl ? r_sigB[D_MAN_W] : r_sigB[S_MAN_W]);
        w_nSigA = w_shA ? {r_sigA[SIG_W-2:0], 1'b0} : r_sigA;
        w_nSigB = w_shB ? {r_sigB[SIG_W-2:0], 1'b0} : r_sigB;
        w_nAlignA  = w_isDbl ? w_nSigA[D_MAN_W] : w_nSigA[S_MAN_W];
        w_nAlignB  = w_isDbl ? w_nSigB[D_MAN_W] : w_nSigB[S_MAN_W];
        w_normDone = (!r_subA || w_nAlignA) && (!r_subB || w_nAlignB);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_inReady  <= 1'b0;
            r_outValid <= 1'b0;
            r_op       <= '0;
            r_sigA     <= '0;
            r_sigB     <= '0;
            r_expA     <= '0;
            r_expB     <= '0;
            r_signA    <= 1'b0;
            r_signB    <= 1'b0;
            r_infA     <= 1'b0;
            r_infB     <= 1'b0;
            r_zeroA    <= 1'b0;
            r_zeroB    <= 1'b0;
            r_nanA     <= 1'b0;
            r_nanB     <= 1'b0;
            r_normA    <= 1'b0;
            r_normB    <= 1'b0;
            r_subA     <= 1'b0;
            r_subB     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (!r_inReady) begin
                        r_inReady <= 1'b1;
                    end else if (in_valid) begin
                        r_inReady <= 1'b0;
                        r_op      <= operation;
                        r_sigA    <= w_decA.sig;
                        r_sigB    <= w_decB.sig;
                        r_expA    <= w_decA.exp;
                        r_expB    <= w_decB.exp;
                        r_signA   <= w_decA.sign;
                        r_signB   <= w_decB.sign;
                        r_infA    <= w_decA.inf;
                        r_infB    <= w_decB.inf;
                        r_zeroA   <= w_decA.zero;
                        r_zeroB   <= w_decB.zero;
                        r_nanA    <= w_decA.nan;
                        r_nanB    <= w_decB.nan;
                        r_normA   <= w_decA.normal;
                        r_normB   <= w_decB.normal;
                        r_subA    <= w_decA.sub;
                        r_subB    <= w_decB.sub;
                        if (w_decA.sub || w_decB.sub) begin
                            r_state <= c_NORM;
                        end else begin
                            r_state    <= c_DONE;
                            r_outValid <= 1'b1;
                        end
                    end
                end
                c_NORM: begin
                    r_sigA <= w_nSigA;
                    r_sigB <= w_nSigB;
                    if (w_shA) r_expA <= r_expA - c_ONE;
                    if (w_shB) r_expB <= r_expB - c_ONE;
                    if (w_normDone) begin
                        r_state    <= c_DONE;
                        r_outValid <= 1'b1;
                    end
                end
                c_DONE: begin
                    // in_ready rises only after the handshake cycle.
                    if (out_ready) begin
                        r_state    <= c_IDLE;
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= c_IDLE;
                    r_outValid <= 1'b0;
                    r_inReady  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_inReady;
    assign out_valid   = r_outValid;
    assign op          = r_op;
    assign out_a       = r_sigA;
    assign out_b       = r_sigB;
    assign exp_a       = r_expA;
    assign exp_b       = r_expB;
    assign sign_a      = r_signA;
    assign sign_b      = r_signB;
    assign inf_a       = r_infA;
    assign inf_b       = r_infB;
    assign zero_a      = r_zeroA;
    assign zero_b      = r_zeroB;
    assign nan_a       = r_nanA;
    assign nan_b       = r_nanB;
    assign normal_a    = r_normA;
    assign normal_b    = r_normB;
    assign subnormal_a = r_subA;
    assign subnormal_b = r_subB;

endmodule
`default_nettype wire
